// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use hazard detection, external stall hold,
// branch-flush bubble insertion and a saturating load-use bubble counter.
//
// state  | meaning
// RUN    | normal flow, ID/EX loads the decoded instruction each edge
// BUBBLE | a load-use bubble sits in EX, the dependent instruction waits in ID
// HOLD   | downstream stall, every ID/EX register frozen
module idex_stage #(
   parameter int unsigned DATA_W = 64,
   parameter logic [4:0]  ZR     = 5'b11111
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              id_valid,
   input  logic [4:0]        id_Rn,
   input  logic [4:0]        id_Rm,
   input  logic [4:0]        id_Rd,
   input  logic              id_RegWrite,
   input  logic              id_MemRead,
   input  logic              id_MemWrite,
   input  logic              id_ALUSrc,
   input  logic              id_BR,
   input  logic [2:0]        id_ALUOp,
   input  logic [DATA_W-1:0] id_rdata1,
   input  logic [DATA_W-1:0] id_rdata2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic              flush,
   input  logic              ext_stall,
   output logic              ex_valid,
   output logic [4:0]        ex_Rn,
   output logic [4:0]        ex_Rm,
   output logic [4:0]        ex_Rd,
   output logic              ex_RegWrite,
   output logic              ex_MemRead,
   output logic              ex_MemWrite,
   output logic              ex_ALUSrc,
   output logic              ex_BR,
   output logic [2:0]        ex_ALUOp,
   output logic [DATA_W-1:0] ex_rdata1,
   output logic [DATA_W-1:0] ex_rdata2,
   output logic [DATA_W-1:0] ex_imm,
   output logic              stall_if,
   output logic [1:0]        state,
   output logic [15:0]       load_use_count
);

   localparam logic [1:0] ST_RUN    = 2'b00;
   localparam logic [1:0] ST_BUBBLE = 2'b01;
   localparam logic [1:0] ST_HOLD   = 2'b10;

   typedef struct packed {
      logic       valid;
      logic [4:0] rn;
      logic [4:0] rm;
      logic [4:0] rd;
      logic       regwrite;
      logic       memread;
      logic       memwrite;
      logic       alusrc;
      logic       br;
      logic [2:0] aluop;
   } ctl_t;

   // Register indices point at XZR so forwarding never matches a bubble.
   localparam ctl_t CTL_BUBBLE = '{
      valid:    1'b0,
      rn:       ZR,
      rm:       ZR,
      rd:       ZR,
      regwrite: 1'b0,
      memread:  1'b0,
      memwrite: 1'b0,
      alusrc:   1'b0,
      br:       1'b0,
      aluop:    3'b000
   };

   ctl_t              ctl_q;
   ctl_t              ctl_d;
   ctl_t              ctl_id;
   logic [DATA_W-1:0] rdata1_q;
   logic [DATA_W-1:0] rdata1_d;
   logic [DATA_W-1:0] rdata2_q;
   logic [DATA_W-1:0] rdata2_d;
   logic [DATA_W-1:0] imm_q;
   logic [DATA_W-1:0] imm_d;
   logic [1:0]        state_q;
   logic [1:0]        state_d;
   logic [15:0]       lu_cnt_q;
   logic [15:0]       lu_cnt_d;

   logic              load_in_ex;
   logic              use_rn;
   logic              use_rm;
   logic              use_rd;
   logic              hazard_raw;
   logic              hazard;
   logic              cnt_sat;

   always_comb begin
      ctl_id.valid    = id_valid;
      ctl_id.rn       = id_Rn;
      ctl_id.rm       = id_Rm;
      ctl_id.rd       = id_Rd;
      ctl_id.regwrite = id_RegWrite;
      ctl_id.memread  = id_MemRead;
      ctl_id.memwrite = id_MemWrite;
      ctl_id.alusrc   = id_ALUSrc;
      ctl_id.br       = id_BR;
      ctl_id.aluop    = id_ALUOp;
   end

   assign load_in_ex = ctl_q.valid & ctl_q.memread & (ctl_q.rd != ZR);
   assign use_rn     = (id_Rn == ctl_q.rd);
   assign use_rm     = (id_Rm == ctl_q.rd) & ~id_ALUSrc;
   assign use_rd     = id_MemWrite & (id_Rd == ctl_q.rd);
   assign hazard_raw = load_in_ex & id_valid & (use_rn | use_rm | use_rd);
   assign hazard     = hazard_raw & ~flush;

   // Gated with reset_n so the hold request drops while reset is asserted.
   assign stall_if   = reset_n & (ext_stall | hazard);

   assign cnt_sat    = (lu_cnt_q == 16'hFFFF);

   always_comb begin
      ctl_d    = ctl_q;
      rdata1_d = rdata1_q;
      rdata2_d = rdata2_q;
      imm_d    = imm_q;
      state_d  = state_q;
      lu_cnt_d = lu_cnt_q;

      if (flush) begin
         ctl_d   = CTL_BUBBLE;
         state_d = ST_RUN;
      end else if (ext_stall) begin
         state_d = ST_HOLD;
      end else if (hazard) begin
         ctl_d   = CTL_BUBBLE;
         state_d = (state_q == ST_RUN) ? ST_BUBBLE : ST_RUN;
         if (!cnt_sat) begin
            lu_cnt_d = lu_cnt_q + 16'd1;
         end
      end else begin
         ctl_d    = ctl_id;
         rdata1_d = id_rdata1;
         rdata2_d = id_rdata2;
         imm_d    = id_imm;
         state_d  = ST_RUN;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctl_q    <= CTL_BUBBLE;
         rdata1_q <= '0;
         rdata2_q <= '0;
         imm_q    <= '0;
         state_q  <= ST_RUN;
         lu_cnt_q <= 16'd0;
      end else begin
         ctl_q    <= ctl_d;
         rdata1_q <= rdata1_d;
         rdata2_q <= rdata2_d;
         imm_q    <= imm_d;
         state_q  <= state_d;
         lu_cnt_q <= lu_cnt_d;
      end
   end

   assign ex_valid       = ctl_q.valid;
   assign ex_Rn          = ctl_q.rn;
   assign ex_Rm          = ctl_q.rm;
   assign ex_Rd          = ctl_q.rd;
   assign ex_RegWrite    = ctl_q.regwrite;
   assign ex_MemRead     = ctl_q.memread;
   assign ex_MemWrite    = ctl_q.memwrite;
   assign ex_ALUSrc      = ctl_q.alusrc;
   assign ex_BR          = ctl_q.br;
   assign ex_ALUOp       = ctl_q.aluop;
   assign ex_rdata1      = rdata1_q;
   assign ex_rdata2      = rdata2_q;
   assign ex_imm         = imm_q;
   assign state          = state_q;
   assign load_use_count = lu_cnt_q;

endmodule

// File: doc/idex_stage.md
IDEX_STAGE -- requirements
Module: idex_stage

Interface
REQ-001 Parameter DATA_W, default 64: width of the register-read and immediate data fields.
REQ-002 Parameter ZR, default 5'b11111: register index of XZR, treated as a never-written register.
REQ-003 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 id_valid  in  1  the ID-stage instruction is real (not a bubble).
REQ-006 id_Rn, id_Rm, id_Rd  in  5 each  decoded register indices.
REQ-007 id_RegWrite, id_MemRead, id_MemWrite, id_ALUSrc, id_BR  in  1 each  decoded control bits.
REQ-008 id_ALUOp  in  3  ALU operation select.
REQ-009 id_rdata1, id_rdata2, id_imm  in  DATA_W each  register-file read data and sign-extended immediate.
REQ-010 flush  in  1  taken-branch kill of the instruction in ID.
REQ-011 ext_stall  in  1  downstream (data memory) stall request.
REQ-012 ex_valid, ex_Rn, ex_Rm, ex_Rd, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_ALUSrc, ex_BR, ex_ALUOp, ex_rdata1, ex_rdata2, ex_imm  out  same widths as the id_ inputs  registered ID/EX copies; these feed forwarding and the ALU.
REQ-013 stall_if  out  1  combinational hold request for the PC and IF/ID register.
REQ-014 state  out  2  FSM state: 00 RUN, 01 BUBBLE, 10 HOLD.
REQ-015 load_use_count  out  16  saturating count of load-use bubbles.

Function
REQ-016 The ID-to-EX latency SHALL be one cycle: when no stall, flush or hazard is active, every ex_ output SHALL equal its id_ input as sampled on the previous rising edge.
REQ-017 A load-use hazard SHALL be flagged when all of the following hold:
- ex_valid, ex_MemRead and id_valid are all 1;
- ex_Rd != ZR;
- at least one of: id_Rn == ex_Rd; (id_Rm == ex_Rd and !id_ALUSrc); (id_MemWrite and id_Rd == ex_Rd).
REQ-018 A bubble SHALL be loaded into the ID/EX register as follows:
- ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_ALUSrc and ex_BR = 0;
- ex_ALUOp = 0;
- ex_Rn, ex_Rm and ex_Rd = ZR, so downstream forwarding never matches a bubble;
- data fields are don't-care.
REQ-019 Update priority per edge: reset_n low, then flush, then ext_stall, then load-use hazard, then normal load.
REQ-020 flush = 1 SHALL load a bubble on the next edge regardless of ext_stall or hazard, and SHALL NOT increment load_use_count.
REQ-021 ext_stall = 1 (no flush) SHALL hold every ex_ register unchanged and assert stall_if in the same cycle.
REQ-022 A hazard (no flush, no ext_stall) SHALL assert stall_if combinationally in the same cycle, load a bubble on the next edge, and increment load_use_count.
REQ-023 stall_if = ext_stall | hazard, with hazard masked while flush = 1.
REQ-024 FSM transitions:
- RUN -> BUBBLE on a hazard;
- RUN or BUBBLE -> HOLD on ext_stall without flush;
- BUBBLE -> RUN otherwise;
- HOLD -> RUN when ext_stall = 0;
- any state -> RUN on flush.
REQ-025 In BUBBLE, hazard detection SHALL be evaluated normally; back-to-back hazards are impossible because ex_MemRead = 0 after a bubble, and the bench SHALL assert this.
REQ-026 load_use_count SHALL saturate at 16'hFFFF and never wrap.
REQ-027 A hazard present during ext_stall SHALL be re-evaluated on the cycle ext_stall falls, and counted only once, when its bubble is inserted.

Reset
REQ-028 Asynchronous assertion of reset_n low SHALL immediately force:
- all ex_ registers to the bubble value;
- state = RUN;
- load_use_count = 0.
stall_if is combinational and SHALL follow as 0 while reset_n is low.
REQ-029 Deassertion SHALL take effect at the next rising edge; reset asserted mid-stall SHALL discard the held instruction.

Verification
REQ-030 LDUR X3 then ADD X5,X3,X4 (id_Rn = 3, ex_Rd = 3, ex_MemRead = 1) SHALL produce: stall_if = 1 for one cycle; next edge ex_valid = 0, ex_Rd = 31, state = BUBBLE, load_use_count = 1; following edge ADD in EX, state = RUN.
REQ-031 Load to X31 followed by use of X31 SHALL produce stall_if = 0 and no bubble.
REQ-032 Load to X3 followed by ADDI X5,X6,#3 with id_Rm = 3 and id_ALUSrc = 1 SHALL produce no stall.
REQ-033 ext_stall held for 3 cycles SHALL keep the ex_ outputs constant, state = HOLD and stall_if = 1; the cycle after release SHALL show state = RUN and the ex_ registers loading id_ inputs.
REQ-034 flush and a hazard in the same cycle SHALL produce a bubble on the next edge with load_use_count unchanged and state = RUN.
REQ-035 Preload load_use_count to 16'hFFFE and force two hazards: the count SHALL read FFFF, then stay FFFF; reset_n low mid-sequence SHALL clear it to 0 asynchronously.
